// File: rtl/vx_alu_req_skid_buf.sv
// Two-entry skid buffer between dispatch and ALU.
// in_req_ready depends only on local flops.
module vx_alu_req_skid_buf #(
  parameter int PERF_CTR_BITS = 32
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         in_req_valid,
  output logic         in_req_ready,
  input  logic [43:0]  in_req_uuid,
  input  logic [1:0]   in_req_wid,
  input  logic [3:0]   in_req_tmask,
  input  logic [31:0]  in_req_PC,
  input  logic [31:0]  in_req_next_PC,
  input  logic [3:0]   in_req_op_type,
  input  logic [2:0]   in_req_op_mod,
  input  logic         in_req_use_PC,
  input  logic         in_req_use_imm,
  input  logic [31:0]  in_req_imm,
  input  logic [11:0]  in_req_u_12,
  input  logic [1:0]   in_req_tid,
  input  logic [127:0] in_req_rs1_data,
  input  logic [127:0] in_req_rs2_data,
  input  logic [4:0]   in_req_rd,
  input  logic         in_req_wb,
  input  logic [2:0]   in_req_func3,
  input  logic [6:0]   in_req_func7,

  output logic         out_req_valid,
  input  logic         out_req_ready,
  output logic [43:0]  out_req_uuid,
  output logic [1:0]   out_req_wid,
  output logic [3:0]   out_req_tmask,
  output logic [31:0]  out_req_PC,
  output logic [31:0]  out_req_next_PC,
  output logic [3:0]   out_req_op_type,
  output logic [2:0]   out_req_op_mod,
  output logic         out_req_use_PC,
  output logic         out_req_use_imm,
  output logic [31:0]  out_req_imm,
  output logic [11:0]  out_req_u_12,
  output logic [1:0]   out_req_tid,
  output logic [127:0] out_req_rs1_data,
  output logic [127:0] out_req_rs2_data,
  output logic [4:0]   out_req_rd,
  output logic         out_req_wb,
  output logic [2:0]   out_req_func3,
  output logic [6:0]   out_req_func7
`ifdef VX_ALU_SKID_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  localparam int PW = 441;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] main_data_q, main_data_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic [PW-1:0] in_data;
  logic          xfer_in;
  logic          xfer_out;

  assign in_data = {
    in_req_uuid, in_req_wid, in_req_tmask,
    in_req_PC, in_req_next_PC,
    in_req_op_type, in_req_op_mod,
    in_req_use_PC, in_req_use_imm,
    in_req_imm, in_req_u_12, in_req_tid,
    in_req_rs1_data, in_req_rs2_data,
    in_req_rd, in_req_wb,
    in_req_func3, in_req_func7
  };

  assign {
    out_req_uuid, out_req_wid, out_req_tmask,
    out_req_PC, out_req_next_PC,
    out_req_op_type, out_req_op_mod,
    out_req_use_PC, out_req_use_imm,
    out_req_imm, out_req_u_12, out_req_tid,
    out_req_rs1_data, out_req_rs2_data,
    out_req_rd, out_req_wb,
    out_req_func3, out_req_func7
  } = main_data_q;

  assign out_req_valid = main_valid_q;
  assign in_req_ready  = !skid_valid_q;

  assign xfer_in  = in_req_valid & in_req_ready;
  assign xfer_out = out_req_valid & out_req_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    case ({main_valid_q, skid_valid_q})
      ST_EMPTY: begin
        if (xfer_in) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end
      end
      ST_ONE: begin
        if (xfer_in && xfer_out) begin
          main_data_d = in_data;
        end else if (xfer_in) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else if (xfer_out) begin
          main_valid_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          skid_valid_d = 1'b0;
          main_data_d  = skid_data_q;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    skid_data_q <= skid_data_d;
  end

`ifdef VX_ALU_SKID_PERF_EN
  logic [PERF_CTR_BITS-1:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (in_req_valid && !in_req_ready) begin
      perf_d = perf_q + PERF_CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stalls = perf_q;
`endif

endmodule
